prefix_addsub_pipe: RTL

//  Pipelined, parametrised Kogge-Stone prefix adder/subtractor with valid/ready handshakes.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/prefix_addsub_pipe_level.sv | 22 ++
 rtl/prefix_addsub_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared sizing helpers and prefix pipeline slot layout for prefix_addsub_pipe
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Slot payload width depends on the instance N, so the struct is built per instance from this macro.
`define ADDER_PG_SLOT_T(W) struct packed { \
    logic [(W)-1:0] p;                     \
    logic [(W)-1:0] g;                     \
    logic [(W)-1:0] p0;                    \
    logic           c0;                    \
    logic           valid;                 \
}

package adder_pkg;

    function automatic int levels(input int n);
        return $clog2(n);
    endfunction

    function automatic int lat(input int n, input int reg_every);
        return 2 + (levels(n) - 1) / reg_every;
    endfunction

endpackage

`endif

// File: rtl/prefix_addsub_pipe_level.sv
// rtl/prefix_addsub_pipe_level.sv - one combinational Kogge-Stone prefix level with span D
module prefix_level #(
    parameter int N = 32,
    parameter int D = 1
) (
    input  logic [N-1:0] p_in,
    input  logic [N-1:0] g_in,
    output logic [N-1:0] p_out,
    output logic [N-1:0] g_out
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i >= D) begin : g_merge
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-D]);
            assign p_out[i] = p_in[i] & p_in[i-D];
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/prefix_addsub_pipe.sv
// rtl/prefix_addsub_pipe.sv - pipelined Kogge-Stone add/sub with valid/ready; PREFIX_ADDSUB_FLAGS_EN adds zero/neg
module prefix_addsub_pipe
    import adder_pkg::*;
#(
    parameter int N         = 32,
    parameter int REG_EVERY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
`ifdef PREFIX_ADDSUB_FLAGS_EN
    output logic         zero,
    output logic         neg,
`endif
    output logic         ovf
);

    localparam int LEVELS = levels(N);
    localparam int NS     = lat(N, REG_EVERY) - 1;

    typedef `ADDER_PG_SLOT_T(N) pg_slot_t;

    pg_slot_t       slot_q [NS];
    pg_slot_t       slot_d [NS];
    logic [N-1:0]   lin_p  [LEVELS];
    logic [N-1:0]   lin_g  [LEVELS];
    logic [N-1:0]   lout_p [LEVELS];
    logic [N-1:0]   lout_g [LEVELS];
    logic [NS:0]    vld;
    logic [NS:0]    adv;
    logic [N-1:0]   b_eff;
    logic           c0_in;
    logic [N:0]     c;
    logic [N-1:0]   sum_d;
    logic           out_valid_q;

    assign b_eff = sub ? ~b : b;
    assign c0_in = sub ? ~cin : cin;

    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        if (s % REG_EVERY == 0) begin : g_from_slot
            assign lin_p[s] = slot_q[s / REG_EVERY].p;
            assign lin_g[s] = slot_q[s / REG_EVERY].g;
        end else begin : g_chain
            assign lin_p[s] = lout_p[s-1];
            assign lin_g[s] = lout_g[s-1];
        end
        prefix_level #(.N(N), .D(1 << s)) u_level (
            .p_in  (lin_p[s]),
            .g_in  (lin_g[s]),
            .p_out (lout_p[s]),
            .g_out (lout_g[s])
        );
    end

    // Handshake: a slot moves on when its successor is empty or itself moving this cycle.
    always_comb begin
        vld = '0;
        adv = '0;
        for (int j = 0; j < NS; j++) vld[j] = slot_q[j].valid;
        vld[NS] = out_valid_q;
        adv[NS] = out_valid_q && out_ready;
        for (int j = NS - 1; j >= 0; j--) adv[j] = vld[j] && (!vld[j+1] || adv[j+1]);
    end

    assign in_ready = !vld[0] || adv[0];

    always_comb begin
        for (int j = 0; j < NS; j++) slot_d[j] = slot_q[j];
        slot_d[0].p     = a ^ b_eff;
        slot_d[0].g     = a & b_eff;
        slot_d[0].p0    = a ^ b_eff;
        slot_d[0].c0    = c0_in;
        slot_d[0].valid = in_valid;
        for (int j = 1; j < NS; j++) begin
            slot_d[j].p     = lout_p[j*REG_EVERY-1];
            slot_d[j].g     = lout_g[j*REG_EVERY-1];
            slot_d[j].p0    = slot_q[j-1].p0;
            slot_d[j].c0    = slot_q[j-1].c0;
            slot_d[j].valid = slot_q[j-1].valid;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NS; j++) begin
            if (reset) begin
                slot_q[j].valid <= 1'b0;
            end else if (!vld[j] || adv[j]) begin
                slot_q[j] <= slot_d[j];
            end
        end
    end

    always_comb begin
        c    = '0;
        c[0] = slot_q[NS-1].c0;
        for (int i = 0; i < N; i++) begin
            c[i+1] = lout_g[LEVELS-1][i] | (lout_p[LEVELS-1][i] & slot_q[NS-1].c0);
        end
        sum_d = slot_q[NS-1].p0 ^ c[N-1:0];
    end

    // Output payload only loads on a real beat so a drained pipe keeps its last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
`ifdef PREFIX_ADDSUB_FLAGS_EN
            zero        <= 1'b0;
            neg         <= 1'b0;
`endif
        end else if (!vld[NS] || adv[NS]) begin
            out_valid_q <= vld[NS-1];
            if (vld[NS-1]) begin
                sum  <= sum_d;
                cout <= c[N];
                ovf  <= c[N] ^ c[N-1];
`ifdef PREFIX_ADDSUB_FLAGS_EN
                zero <= (sum_d == '0);
                neg  <= sum_d[N-1];
`endif
            end
        end
    end

    assign out_valid = out_valid_q;

endmodule
